fx2lp_stream_writer: RTL

- Synchronous slave-FIFO writer that drains 32-bit {Q,I} sample words from the IFCLK-side FIFO read port.
- Serialises each word into four bytes on the FX2LP 8-bit FD bus, with SLWR strobes and flag-based backpressure.
- Commits short packets with PKTEND after an idle timeout or when streaming is disabled.
- Runs entirely on the 32 MHz IFCLK domain, directly downstream of the sample FIFO.

---
 rtl/fx2lp_pkg.sv | 31 +++
 rtl/fx2lp_stream_writer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fx2lp_pkg.sv
// Shared types and constants for the FX2LP slave-FIFO stream writer.
package fx2lp_pkg;

    typedef enum logic [1:0] {
        ST_STREAM = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_PKTEND = 2'd2
    } state_e;

    localparam logic [1:0] EP2_ADDR = 2'b00;
    localparam logic [1:0] EP4_ADDR = 2'b01;
    localparam logic [1:0] EP6_ADDR = 2'b10;
    localparam logic [1:0] EP8_ADDR = 2'b11;

    localparam int unsigned FLAG_W           = 3;
    localparam int unsigned AF_IDX_DEFAULT   = 0;
    localparam int unsigned FULL_IDX_DEFAULT = 1;

    // Byte lane of a {Q,I} word; lane 0 is the first byte on the FD bus.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] lane;
        case (idx)
            2'd0:    lane = word[7:0];
            2'd1:    lane = word[15:8];
            2'd2:    lane = word[23:16];
            default: lane = word[31:24];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/fx2lp_stream_writer.sv
// Serialises 32-bit {Q,I} words onto the FX2LP 8-bit slave-FIFO bus and commits
// short packets with PKTEND after an idle timeout or when streaming stops.
module fx2lp_stream_writer
    import fx2lp_pkg::*;
#(
    parameter int unsigned PKT_BYTES = 512,
    parameter int unsigned TIMEOUT   = 4096,
    parameter logic [1:0]  EP_ADDR   = EP2_ADDR,
    parameter int unsigned AF_IDX    = AF_IDX_DEFAULT,
    parameter int unsigned FULL_IDX  = FULL_IDX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        fd,
    output logic              slwr_n,
    output logic              slrd_n,
    output logic              sloe_n,
    output logic [1:0]        fifoadr,
    output logic              pktend_n,
    input  logic [FLAG_W-1:0] flag_n,
    output logic [15:0]       pkt_count
);

    localparam int unsigned BCNT_W = $clog2(PKT_BYTES + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    state_e              r_state;
    state_e              w_next_state;
    logic [FLAG_W-1:0]   r_flag;
    logic [31:0]         r_word;
    logic                r_word_valid;
    logic [1:0]          r_byte_idx;
    logic [7:0]          r_fd;
    logic                r_slwr_n;
    logic                r_pktend_n;
    logic [BCNT_W-1:0]   r_byte_cnt;
    logic [IDLE_W-1:0]   r_idle_cnt;
    logic [15:0]         r_pkt_count;

    logic                w_can_write;
    logic                w_write_now;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_timeout;
    logic                w_flush_req;
    logic                w_pktend_n_nxt;
    logic                w_unused;

    // Flags are active-low: writing is allowed only with both almost-full and full inactive.
    assign w_can_write = r_flag[AF_IDX] & r_flag[FULL_IDX];
    assign w_write_now = r_word_valid & w_can_write;
    assign w_accept    = in_valid & w_in_ready;
    assign w_timeout   = (r_idle_cnt == IDLE_W'(TIMEOUT));
    assign w_unused    = ^r_flag;

    // A word arriving together with the timeout wins; disabling always flushes.
    assign w_flush_req = !r_word_valid && (r_byte_cnt != '0)
                         && (!enable || (w_timeout && !in_valid));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_STREAM;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_in_ready     = 1'b0;
        w_pktend_n_nxt = 1'b1;
        unique case (r_state)
            ST_STREAM: begin
                w_in_ready = enable & (!r_word_valid | ((r_byte_idx == 2'd3) & w_write_now));
                if (w_flush_req) begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (r_flag[FULL_IDX]) begin
                    w_next_state   = ST_PKTEND;
                    w_pktend_n_nxt = 1'b0;
                end
            end
            ST_PKTEND: begin
                w_next_state = ST_STREAM;
            end
            default: begin
                w_next_state = ST_STREAM;
            end
        endcase
        if (reset) begin
            w_in_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flag       <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_byte_idx   <= 2'd0;
            r_fd         <= 8'd0;
            r_slwr_n     <= 1'b1;
            r_pktend_n   <= 1'b1;
            r_byte_cnt   <= '0;
            r_idle_cnt   <= '0;
            r_pkt_count  <= 16'd0;
        end else begin
            r_flag     <= flag_n;
            r_pktend_n <= w_pktend_n_nxt;

            if (w_accept) begin
                r_word       <= in_data;
                r_word_valid <= 1'b1;
                r_byte_idx   <= 2'd0;
            end else if (w_write_now) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                if (r_byte_idx == 2'd3) begin
                    r_word_valid <= 1'b0;
                end
            end

            // On a stall fd keeps its last value and only the strobe drops.
            if (w_write_now) begin
                r_fd     <= byte_lane(r_word, r_byte_idx);
                r_slwr_n <= 1'b0;
            end else begin
                r_slwr_n <= 1'b1;
            end

            // Full packets are auto-committed by the FX2; short ones by PKTEND.
            if (r_state == ST_PKTEND) begin
                r_byte_cnt  <= '0;
                r_pkt_count <= r_pkt_count + 16'd1;
            end else if (w_write_now) begin
                if (r_byte_cnt == BCNT_W'(PKT_BYTES - 1)) begin
                    r_byte_cnt  <= '0;
                    r_pkt_count <= r_pkt_count + 16'd1;
                end else begin
                    r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
                end
            end

            if (w_write_now || (r_state == ST_PKTEND)) begin
                r_idle_cnt <= '0;
            end else if (!w_timeout) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign fd        = r_fd;
    assign slwr_n    = r_slwr_n;
    assign slrd_n    = 1'b1;
    assign sloe_n    = 1'b1;
    assign fifoadr   = EP_ADDR;
    assign pktend_n  = r_pktend_n;
    assign pkt_count = r_pkt_count;

endmodule
